soc_rst_sequencer: RTL and testbench

- Board-level reset/bring-up controller for the kc705 SoC.
- Sequence: hold reset for a fixed number of cycles, release DDR3, wait for DDR3 calibration, release PCIe, wait for link-up, then release the system core reset.
- Monitors both status inputs in RUN, drops into a sticky ERROR state on timeout or status loss, and exposes state and error code for GPIO/LED debug.

---
 rtl/soc_rst_sequencer.sv | 175 +++++++++++++++++
 tb/tb_soc_rst_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/soc_rst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | soc_rst_sequencer: kc705 reset/bring-up sequencer (HOLD->DDR3->PCIe->RUN). |
// | Optional PCIe stage enabled by RSTSEQ_PCIE_EN.  Rev 1.0                    |
// +----------------------------------------------------------------------------+
module soc_rst_sequencer #(
  parameter int RST_HOLD_CYCLES = 11,
  parameter int CALIB_TIMEOUT   = 1048576,
  parameter int LINK_TIMEOUT    = 1048576
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ddr_calib_done,
  input  logic       i_pcie_link_up,
  input  logic       i_restart,
  output logic       o_ddr_rst,
  output logic       o_pcie_nrst,
  output logic       o_sys_rst,
  output logic       o_ready,
  output logic       o_error,
  output logic [2:0] o_err_code,
  output logic [2:0] o_state
);

  localparam int MAX_A = (RST_HOLD_CYCLES > CALIB_TIMEOUT) ? RST_HOLD_CYCLES : CALIB_TIMEOUT;
  localparam int MAX_V = (MAX_A > LINK_TIMEOUT) ? MAX_A : LINK_TIMEOUT;
  localparam int CW    = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_TIMEOUT - 1);
  localparam logic [CW-1:0] LINK_LAST  = CW'(LINK_TIMEOUT - 1);
  localparam bit CALIB_TO_EN = (CALIB_TIMEOUT != 0);
  localparam bit LINK_TO_EN  = (LINK_TIMEOUT != 0);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_DDR_WAIT  = 3'd1,
    ST_PCIE_WAIT = 3'd2,
    ST_RUN       = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          calib_meta_q, calib_sync_q;
  logic          link_sync;
  logic          ddr_rst_q, pcie_nrst_q, sys_rst_q, ready_q, error_q;
  logic          ddr_rst_d, pcie_nrst_d, sys_rst_d, ready_d, error_d;

`ifdef RSTSEQ_PCIE_EN
  logic link_meta_q, link_sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      link_meta_q <= 1'b0;
      link_sync_q <= 1'b0;
    end else begin
      link_meta_q <= i_pcie_link_up;
      link_sync_q <= link_meta_q;
    end
  end

  assign link_sync = link_sync_q;
`else
  logic unused_link;
  assign unused_link = i_pcie_link_up;
  assign link_sync   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_DDR_WAIT;
      end
      ST_DDR_WAIT: begin
        if (calib_sync_q) begin
`ifdef RSTSEQ_PCIE_EN
          state_d = ST_PCIE_WAIT;
`else
          state_d = ST_RUN;
`endif
        end else if (CALIB_TO_EN && cnt_q == CALIB_LAST) begin
          state_d    = ST_ERROR;
          err_code_d = 3'd1;
        end
      end
`ifdef RSTSEQ_PCIE_EN
      ST_PCIE_WAIT: begin
        // Losing calibration outranks both link-up and timeout.
        if (!calib_sync_q) begin
          state_d    = ST_ERROR;
          err_code_d = 3'd3;
        end else if (link_sync) begin
          state_d = ST_RUN;
        end else if (LINK_TO_EN && cnt_q == LINK_LAST) begin
          state_d    = ST_ERROR;
          err_code_d = 3'd2;
        end
      end
`endif
      ST_RUN: begin
        if (!calib_sync_q) begin
          state_d    = ST_ERROR;
          err_code_d = 3'd3;
`ifdef RSTSEQ_PCIE_EN
        end else if (!link_sync) begin
          state_d    = ST_ERROR;
          err_code_d = 3'd4;
`endif
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_HOLD;
    endcase

    if (i_restart) begin
      state_d    = ST_HOLD;
      err_code_d = 3'd0;
    end

    if (i_restart || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q != {CW{1'b1}})          cnt_d = cnt_q + 1'b1;
    else                                   cnt_d = cnt_q;

    // Outputs are decoded from the next state so they change with the state.
    ddr_rst_d = (state_d == ST_HOLD) || (state_d == ST_ERROR);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    error_d   = (state_d == ST_ERROR);
`ifdef RSTSEQ_PCIE_EN
    pcie_nrst_d = (state_d == ST_PCIE_WAIT) || (state_d == ST_RUN);
`else
    pcie_nrst_d = ~ddr_rst_d;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      err_code_q   <= 3'd0;
      calib_meta_q <= 1'b0;
      calib_sync_q <= 1'b0;
      ddr_rst_q    <= 1'b1;
      pcie_nrst_q  <= 1'b0;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_code_q   <= err_code_d;
      calib_meta_q <= i_ddr_calib_done;
      calib_sync_q <= calib_meta_q;
      ddr_rst_q    <= ddr_rst_d;
      pcie_nrst_q  <= pcie_nrst_d;
      sys_rst_q    <= sys_rst_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  assign o_ddr_rst   = ddr_rst_q;
  assign o_pcie_nrst = pcie_nrst_q;
  assign o_sys_rst   = sys_rst_q;
  assign o_ready     = ready_q;
  assign o_error     = error_q;
  assign o_err_code  = err_code_q;
  assign o_state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_rst_sequencer.sv
`default_nettype none
// Bench for soc_rst_sequencer: cycle-by-cycle reference model plus directed
// literal checkpoints. Follows RSTSEQ_PCIE_EN the same way as the design.
module tb_soc_rst_sequencer;

  localparam int HOLD = 11;
  localparam int CTO  = 16;
  localparam int LTO  = 8;
`ifdef RSTSEQ_PCIE_EN
  localparam bit PCIE = 1'b1;
`else
  localparam bit PCIE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       calib = 1'b0;
  logic       link = 1'b0;
  logic       restart = 1'b0;
  logic       ddr_rst, pcie_nrst, sys_rst, ready, error;
  logic [2:0] err_code, state;

  int checks   = 0;
  int failures = 0;

  soc_rst_sequencer #(
    .RST_HOLD_CYCLES(HOLD),
    .CALIB_TIMEOUT  (CTO),
    .LINK_TIMEOUT   (LTO)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ddr_calib_done(calib),
    .i_pcie_link_up  (link),
    .i_restart       (restart),
    .o_ddr_rst       (ddr_rst),
    .o_pcie_nrst     (pcie_nrst),
    .o_sys_rst       (sys_rst),
    .o_ready         (ready),
    .o_error         (error),
    .o_err_code      (err_code),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  // Reference: phase number, cycles spent in the phase, and the last few
  // input samples (status is seen by the sequencer two samples late).
  int   m_phase = 0;
  int   m_age   = 0;
  int   m_code  = 0;
  bit   m_valid = 1'b0;
  bit   calib_hist[2];
  bit   link_hist[2];

  always @(posedge clk) begin : model
    int nxt;
    bit c_seen, l_seen;
    if (rst) begin
      m_phase = 0; m_age = 0; m_code = 0; m_valid = 1'b1;
      calib_hist[0] = 1'b0; calib_hist[1] = 1'b0;
      link_hist[0]  = 1'b0; link_hist[1]  = 1'b0;
    end else begin
      c_seen = calib_hist[1];
      l_seen = link_hist[1];
      nxt = m_phase;
      if (m_phase == 0 && m_age + 1 >= HOLD) nxt = 1;
      else if (m_phase == 1) begin
        if (c_seen) nxt = PCIE ? 2 : 3;
        else if (CTO != 0 && m_age + 1 >= CTO) begin nxt = 4; m_code = 1; end
      end else if (m_phase == 2) begin
        if (!c_seen) begin nxt = 4; m_code = 3; end
        else if (l_seen) nxt = 3;
        else if (LTO != 0 && m_age + 1 >= LTO) begin nxt = 4; m_code = 2; end
      end else if (m_phase == 3) begin
        if (!c_seen) begin nxt = 4; m_code = 3; end
        else if (PCIE && !l_seen) begin nxt = 4; m_code = 4; end
      end
      if (restart) begin nxt = 0; m_code = 0; end
      m_age   = (restart || nxt != m_phase) ? 0 : m_age + 1;
      m_phase = nxt;
      calib_hist[1] = calib_hist[0]; calib_hist[0] = calib;
      link_hist[1]  = link_hist[0];  link_hist[0]  = link;
    end
  end

  task automatic cycle_cmp();
    logic [9:0] exp_v, act_v;
    bit e_ddr;
    if (!m_valid) return;
    e_ddr = (m_phase == 0) || (m_phase == 4);
    exp_v = {e_ddr,
             PCIE ? (m_phase == 2 || m_phase == 3) : !e_ddr,
             m_phase != 3, m_phase == 3, m_phase == 4,
             m_code[2:0], m_phase[2:0] == 3'd4 ? 2'b10 : m_phase[1:0]};
    act_v = {ddr_rst, pcie_nrst, sys_rst, ready, error, err_code, state[2] ? 2'b10 : state[1:0]};
    checks++;
    if (act_v !== exp_v || state !== m_phase[2:0]) begin
      failures++;
      $display("FAIL cycle_model t=%0t got outs=%b state=%0d want outs=%b state=%0d",
               $time, act_v, state, exp_v, m_phase);
    end
  endtask

  // Advance n clock edges; leaves the caller at the falling edge after the last one.
  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cycle_cmp();
    end
  endtask

  task automatic expect_st(input string nm, input int st, input int code, input bit err);
    checks++;
    if (state !== st[2:0] || err_code !== code[2:0] || error !== err) begin
      failures++;
      $display("FAIL %s got state=%0d code=%0d err=%b want state=%0d code=%0d err=%b",
               nm, state, err_code, error, st, code, err);
    end
  endtask

  task automatic expect_rst(input string nm, input logic [3:0] want);
    checks++;
    if ({ddr_rst, pcie_nrst, sys_rst, ready} !== want) begin
      failures++;
      $display("FAIL %s got ddr/nrst/sys/rdy=%b want %b", nm,
               {ddr_rst, pcie_nrst, sys_rst, ready}, want);
    end
  endtask

  initial begin
    go(3);
    expect_st("reset", 0, 0, 1'b0);
    expect_rst("reset_outs", 4'b1010);
    rst = 1'b0;                         // edge 0 of the first run
    go(10); expect_st("hold_end", 0, 0, 1'b0);
    go(1);  expect_st("ddr_release", 1, 0, 1'b0);
    expect_rst("ddr_release_outs", PCIE ? 4'b0010 : 4'b0110);
    go(2);  calib = 1'b1;               // edge 13
    go(3);  expect_st("calib_seen", PCIE ? 2 : 3, 0, 1'b0);
    expect_rst("calib_seen_outs", PCIE ? 4'b0110 : 4'b0101);
    go(2);  link = 1'b1;                // edge 18
    go(3);  expect_st("run", 3, 0, 1'b0);
    expect_rst("run_outs", 4'b0101);
    go(2);  calib = 1'b0; link = 1'b0;  // edge 23
    go(2);  expect_st("run_before_drop", 3, 0, 1'b0);
    go(1);  expect_st("both_drop", 4, 3, 1'b1);
    expect_rst("both_drop_outs", 4'b1010);
    go(4);  expect_st("err_sticky", 4, 3, 1'b1);
    restart = 1'b1;                     // edge 30
    go(1);  restart = 1'b0; calib = 1'b1; link = 1'b1;
    expect_st("restart", 0, 0, 1'b0);   // edge 31
    go(11); expect_st("rerun_ddr", 1, 0, 1'b0);
    go(1);  expect_st("rerun_next", PCIE ? 2 : 3, 0, 1'b0);
    go(1);  expect_st("rerun_run", 3, 0, 1'b0);
    go(1);  calib = 1'b0; restart = 1'b1;  // edge 45
    go(1);  restart = 1'b0;
    expect_st("restart_from_run", 0, 0, 1'b0);
    go(11); expect_st("ddr_wait2", 1, 0, 1'b0);
    go(15); expect_st("pre_calib_to", 1, 0, 1'b0);
    go(1);  expect_st("calib_timeout", 4, 1, 1'b1);
    expect_rst("calib_timeout_outs", 4'b1010);
    go(2);  calib = 1'b1; link = 1'b0; restart = 1'b1;  // edge 75
    go(1);  restart = 1'b0;
    go(12); expect_st("link_wait", PCIE ? 2 : 3, 0, 1'b0);
    go(7);  expect_st("pre_link_to", PCIE ? 2 : 3, 0, 1'b0);
    go(1);  expect_st("link_timeout", PCIE ? 4 : 3, PCIE ? 2 : 0, PCIE);
    go(2);  calib = 1'b0; restart = 1'b1;  // edge 98
    go(1);  restart = 1'b0;
    go(14); expect_st("mid_ddr_wait", 1, 0, 1'b0);
    rst = 1'b1; restart = 1'b1;         // edge 113
    go(1);  expect_st("rst_over_restart", 0, 0, 1'b0);
    expect_rst("rst_over_restart_outs", 4'b1010);
    rst = 1'b0; restart = 1'b0;         // edge 0 of the last run
    go(24); calib = 1'b1;
    go(3);  expect_st("done_beats_timeout", PCIE ? 2 : 3, 0, 1'b0);
    go(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
